// File: rtl/apb_mem_ws.sv
// APB4 slave scratch memory with byte strobes, configurable wait states and
// PSLVERR on out-of-range word addresses.
module apb_mem_ws #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                    pclk,
    input  logic                    PRESETn,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic                    pwrite,
    input  logic                    psel,
    input  logic                    penable,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned LIM_W  = ADDR_WIDTH + 1;
    localparam logic [LIM_W-1:0] DEPTH_LIM = LIM_W'(MEM_DEPTH);
    localparam logic [3:0]       WS_LOAD   = 4'(WAIT_STATES);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic [3:0]            cnt;
    logic [3:0]            cnt_next;
    logic                  pready_next;
    logic                  pslverr_next;
    logic [DATA_WIDTH-1:0] prdata_next;

    logic [IDX_W-1:0]      idx_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     strb_q;
    logic                  err_q;

    logic                  setup_c;
    logic                  raise_c;
    logic                  mem_we_c;
    logic [IDX_W-1:0]      cur_idx_c;
    logic                  cur_write_c;
    logic                  cur_err_c;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    assign setup_c = (state == IDLE) && psel && !penable;

    // On the setup edge the latched copies are not valid yet, so take the live bus.
    assign cur_idx_c   = setup_c ? IDX_W'(paddr) : idx_q;
    assign cur_write_c = setup_c ? pwrite : write_q;
    assign cur_err_c   = setup_c ? ({1'b0, paddr} >= DEPTH_LIM) : err_q;

    // Next-state and next-output logic; SETUP is the first access-phase cycle.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        pready_next  = pready;
        pslverr_next = pslverr;
        prdata_next  = prdata;
        mem_we_c     = 1'b0;
        raise_c      = 1'b0;
        case (state)
            IDLE: begin
                if (setup_c) begin
                    state_next = SETUP;
                    cnt_next   = WS_LOAD;
                    raise_c    = (WS_LOAD == 4'd0);
                end
            end
            SETUP, ACCESS: begin
                if (!psel) begin
                    state_next   = IDLE;
                    cnt_next     = 4'd0;
                    pready_next  = 1'b0;
                    pslverr_next = 1'b0;
                end else if (penable && pready) begin
                    state_next   = IDLE;
                    pready_next  = 1'b0;
                    pslverr_next = 1'b0;
                    mem_we_c     = write_q && !err_q;
                end else begin
                    state_next = ACCESS;
                    if (cnt != 4'd0) begin
                        cnt_next = cnt - 4'd1;
                        raise_c  = (cnt == 4'd1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (raise_c) begin
            pready_next  = 1'b1;
            pslverr_next = cur_err_c;
            if (!cur_write_c) begin
                prdata_next = cur_err_c ? '0 : mem[cur_idx_c];
            end
        end
    end

    // State, wait counter and registered bus outputs.
    always_ff @(posedge pclk or negedge PRESETn) begin
        if (!PRESETn) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            pready  <= pready_next;
            pslverr <= pslverr_next;
            prdata  <= prdata_next;
        end
    end

    // Capture the transfer attributes at the setup edge.
    always_ff @(posedge pclk or negedge PRESETn) begin
        if (!PRESETn) begin
            idx_q   <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            err_q   <= 1'b0;
        end else if (setup_c) begin
            idx_q   <= IDX_W'(paddr);
            write_q <= pwrite;
            wdata_q <= pwdata;
            strb_q  <= pstrb;
            err_q   <= ({1'b0, paddr} >= DEPTH_LIM);
        end
    end

    // Byte-lane write at the completion edge; the array itself is never reset.
    always_ff @(posedge pclk) begin
        if (mem_we_c) begin
            for (int i = 0; i < int'(STRB_W); i++) begin
                if (strb_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_mem_ws.sv
// Bench for apb_mem_ws: three instances (0, 2 and 3 wait states) on a shared
// bus with separate selects, checked against a word/byte-valid reference model.
module tb_apb_mem_ws;

    logic        pclk;
    logic        PRESETn;
    logic [9:0]  paddr;
    logic        pwrite;
    logic [2:0]  psel;
    logic        penable;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata [3];
    logic [2:0]  pready;
    logic [2:0]  pslverr;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mdl      [3][256];
    logic [3:0]  vld      [3][256];
    logic [31:0] last_exp [3];
    logic [31:0] last_msk [3];

    apb_mem_ws #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_ws0 (
        .pclk(pclk), .PRESETn(PRESETn), .paddr(paddr), .pwrite(pwrite), .psel(psel[0]),
        .penable(penable), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata[0]),
        .pready(pready[0]), .pslverr(pslverr[0]));

    apb_mem_ws #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(2)) u_ws2 (
        .pclk(pclk), .PRESETn(PRESETn), .paddr(paddr), .pwrite(pwrite), .psel(psel[1]),
        .penable(penable), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata[1]),
        .pready(pready[1]), .pslverr(pslverr[1]));

    apb_mem_ws #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(3)) u_ws3 (
        .pclk(pclk), .PRESETn(PRESETn), .paddr(paddr), .pwrite(pwrite), .psel(psel[2]),
        .penable(penable), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata[2]),
        .pready(pready[2]), .pslverr(pslverr[2]));

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic int ws_of(input int d);
        case (d)
            0:       return 0;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] v);
        return {{8{v[3]}}, {8{v[2]}}, {8{v[1]}}, {8{v[0]}}};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle(input int n);
        psel    = 3'b000;
        penable = 1'b0;
        repeat (n) @(negedge pclk);
    endtask

    // Setup cycle, then access phase with scrambled bus until pready is seen.
    task automatic begin_xfer(input int d, input bit wr, input logic [9:0] a,
                              input logic [31:0] wd, input logic [3:0] sb, output int acc);
        psel    = 3'b000;
        psel[d] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = wd;
        pstrb   = sb;
        @(negedge pclk);
        penable = 1'b1;
        pwrite  = 1'($urandom);
        paddr   = 10'($urandom);
        pwdata  = $urandom;
        pstrb   = 4'($urandom);
        acc = 1;
        while (pready[d] !== 1'b1 && acc <= 40) begin
            @(negedge pclk);
            acc++;
        end
    endtask

    task automatic xfer(input int d, input bit wr, input logic [9:0] a,
                        input logic [31:0] wd, input logic [3:0] sb, output logic [31:0] rd);
        int          acc;
        bit          oor;
        logic [31:0] exp_d;
        logic [31:0] msk;
        begin_xfer(d, wr, a, wd, sb, acc);
        check("access_len", 32'(acc), 32'(ws_of(d) + 1));
        rd  = prdata[d];
        oor = (a >= 10'd256);
        check("pslverr", 32'(pslverr[d]), 32'(oor));
        if (wr) begin
            check("prdata_hold", prdata[d] & last_msk[d], last_exp[d] & last_msk[d]);
            if (!oor) begin
                for (int i = 0; i < 4; i++) begin
                    if (sb[i]) begin
                        mdl[d][a[7:0]][8*i +: 8] = wd[8*i +: 8];
                        vld[d][a[7:0]][i]        = 1'b1;
                    end
                end
            end
        end else begin
            exp_d = oor ? 32'h0 : mdl[d][a[7:0]];
            msk   = oor ? 32'hFFFF_FFFF : lane_mask(vld[d][a[7:0]]);
            check("rdata", rd & msk, exp_d & msk);
            last_exp[d] = exp_d;
            last_msk[d] = msk;
        end
        @(negedge pclk);
        check("pready_drop", 32'(pready[d]), 32'h0);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            last_exp[d] = 32'h0;
            last_msk[d] = 32'hFFFF_FFFF;
        end
    endtask

    task automatic check_reset_outs(input int d);
        check("rst_pready", 32'(pready[d]), 32'h0);
        check("rst_pslverr", 32'(pslverr[d]), 32'h0);
        check("rst_prdata", prdata[d], 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        int          acc;
        bit          wr;
        logic [9:0]  a;

        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 256; k++) vld[d][k] = 4'h0;
        end
        model_reset();
        PRESETn = 1'b0;
        psel    = 3'b000;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 10'h0;
        pwdata  = 32'h0;
        pstrb   = 4'h0;
        repeat (2) @(negedge pclk);
        for (int d = 0; d < 3; d++) check_reset_outs(d);
        PRESETn = 1'b1;
        @(negedge pclk);

        // Zero wait states: write then read back.
        xfer(0, 1'b1, 10'd5, 32'hABCD1234, 4'hF, rd);
        xfer(0, 1'b0, 10'd5, 32'h0, 4'h0, rd);
        check("t1_rd", rd, 32'hABCD1234);
        bus_idle(1);

        // Two wait states.
        xfer(1, 1'b1, 10'd7, 32'h11223344, 4'hF, rd);
        bus_idle(1);
        xfer(1, 1'b0, 10'd7, 32'h0, 4'h0, rd);
        check("t2_rd", rd, 32'h11223344);
        bus_idle(1);

        // Byte strobes.
        xfer(0, 1'b1, 10'd3, 32'hFFFFFFFF, 4'hF, rd);
        xfer(0, 1'b1, 10'd3, 32'h000000AA, 4'b0001, rd);
        xfer(0, 1'b0, 10'd3, 32'h0, 4'h0, rd);
        check("t3_rd", rd, 32'hFFFFFFAA);
        xfer(0, 1'b1, 10'd3, 32'h12345678, 4'h0, rd);
        xfer(0, 1'b0, 10'd3, 32'h0, 4'h0, rd);
        check("t3_nostrb", rd, 32'hFFFFFFAA);
        bus_idle(1);

        // Out of range, plus the aliased in-range word stays intact.
        xfer(0, 1'b1, 10'd44, 32'h44444444, 4'hF, rd);
        xfer(0, 1'b1, 10'd300, 32'hDEADBEEF, 4'hF, rd);
        xfer(0, 1'b0, 10'd300, 32'h0, 4'h0, rd);
        check("t4_oor_rd", rd, 32'h0);
        xfer(0, 1'b0, 10'd44, 32'h0, 4'h0, rd);
        check("t4_alias", rd, 32'h44444444);
        bus_idle(1);

        // Abort on the three-wait-state instance in the 2nd access cycle.
        xfer(2, 1'b1, 10'd9, 32'h0, 4'hF, rd);
        bus_idle(1);
        psel    = 3'b100;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 10'd9;
        pwdata  = 32'h5A5A5A5A;
        pstrb   = 4'hF;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        check("abort_pready_a", 32'(pready[2]), 32'h0);
        bus_idle(0);
        for (int k = 0; k < 5; k++) begin
            @(negedge pclk);
            check("abort_pready_b", 32'(pready[2]), 32'h0);
        end
        xfer(2, 1'b0, 10'd9, 32'h0, 4'h0, rd);
        check("t5_abort_rd", rd, 32'h0);
        bus_idle(1);

        // Reset in the middle of a read.
        xfer(1, 1'b0, 10'd7, 32'h0, 4'h0, rd);
        begin_xfer(1, 1'b0, 10'd7, 32'h0, 4'h0, acc);
        check("mid_read_ready", 32'(pready[1]), 32'h1);
        PRESETn = 1'b0;
        #1;
        check_reset_outs(1);
        @(negedge pclk);
        bus_idle(0);
        PRESETn = 1'b1;
        model_reset();
        @(negedge pclk);
        check("post_rst_pready", 32'(pready[1]), 32'h0);

        // Reset with a write pending: memory must keep the old word.
        xfer(0, 1'b1, 10'd20, 32'h12345678, 4'hF, rd);
        begin_xfer(0, 1'b1, 10'd20, 32'hCAFEF00D, 4'hF, acc);
        PRESETn = 1'b0;
        #1;
        check_reset_outs(0);
        @(negedge pclk);
        bus_idle(0);
        PRESETn = 1'b1;
        model_reset();
        @(negedge pclk);
        xfer(0, 1'b0, 10'd20, 32'h0, 4'h0, rd);
        check("rst_no_write", rd, 32'h12345678);
        bus_idle(1);

        // penable without a preceding setup is ignored.
        psel    = 3'b001;
        penable = 1'b1;
        pwrite  = 1'b1;
        paddr   = 10'd5;
        pwdata  = 32'h0;
        pstrb   = 4'hF;
        for (int k = 0; k < 3; k++) begin
            @(negedge pclk);
            check("noset_pready", 32'(pready[0]), 32'h0);
        end
        bus_idle(1);
        xfer(0, 1'b0, 10'd5, 32'h0, 4'h0, rd);
        check("noset_rd", rd, 32'hABCD1234);
        bus_idle(1);

        // Back-to-back transfers on every instance.
        for (int d = 0; d < 3; d++) begin
            xfer(d, 1'b1, 10'd1, 32'h1, 4'hF, rd);
            xfer(d, 1'b1, 10'd2, 32'h2, 4'hF, rd);
            xfer(d, 1'b0, 10'd1, 32'h0, 4'h0, rd);
            check("b2b_rd1", rd, 32'h1);
            xfer(d, 1'b0, 10'd2, 32'h0, 4'h0, rd);
            check("b2b_rd2", rd, 32'h2);
            bus_idle(1);
        end

        // Randomized traffic against the model.
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 30; k++) begin
                wr = 1'($urandom);
                if ($urandom_range(0, 4) == 0) a = 10'($urandom_range(256, 1023));
                else                           a = 10'($urandom_range(0, 15));
                xfer(d, wr, a, $urandom, 4'($urandom), rd);
                if ($urandom_range(0, 2) == 0) bus_idle(int'($urandom_range(1, 2)));
            end
            bus_idle(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
